// File: rtl/convertidor_binario_bcd.sv
// -----------------------------------------------------------------------------
// convertidor_binario_bcd
//
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
// clock). It produces four registered BCD digits for the 7-segment display
// path. A conversion starts with a start/done handshake, and the result is
// held until the next conversion completes.
//
// Handshake: `inicio` is sampled on a rising edge and is acted on only while
// idle (`ocupado`=0). `binario` is captured on that same edge. Requests made
// while `ocupado`=1 are dropped and are not queued. `listo` pulses for one
// cycle, in the same cycle that the new digits first become visible.
//
// Optional feature: define BLANCO_CEROS_EN to enable leading-zero blanking.
// Blanked digits show 4'b1111 (all segments off). `unidades` is never blanked.
//
// Parameters:
//   ANCHO     width of the binary input (4..14)
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   inicio    start request
//   binario   unsigned value to convert
//   ocupado   conversion in progress (CONVIERTE or FIN)
//   listo     one-cycle pulse: new digits valid
//   desborde  latched input was above 9999 (held with digits)
//   unidades, decenas, centenas, millares   registered BCD digits
// -----------------------------------------------------------------------------
module convertidor_binario_bcd #(
    parameter int ANCHO = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [ANCHO-1:0] binario,
    output logic             ocupado,
    output logic             listo,
    output logic             desborde,
    output logic [3:0]       unidades,
    output logic [3:0]       decenas,
    output logic [3:0]       centenas,
    output logic [3:0]       millares
);

    localparam int SW = 16 + ANCHO;          // 16 BCD bits above the binary bits
    localparam int CW = $clog2(ANCHO + 1);

`ifdef BLANCO_CEROS_EN
    localparam logic [3:0] RST_MIL = 4'hF;
    localparam logic [3:0] RST_CEN = 4'hF;
    localparam logic [3:0] RST_DEC = 4'hF;
`else
    localparam logic [3:0] RST_MIL = 4'h0;
    localparam logic [3:0] RST_CEN = 4'h0;
    localparam logic [3:0] RST_DEC = 4'h0;
`endif

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        FIN       = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [SW-1:0]    sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       uni_q, uni_d;
    logic [3:0]       dec_q, dec_d;
    logic [3:0]       cen_q, cen_d;
    logic [3:0]       mil_q, mil_d;
    logic             desb_q, desb_d;

    // Datapath for one conversion step: add 3 to each BCD nibble >= 5,
    // then shift the whole register left by one bit.
    logic [SW-1:0]    sr_aj;
    logic [SW-1:0]    sr_desp;
    logic [3:0]       bcd_mil, bcd_cen, bcd_dec, bcd_uni;

    always_comb begin
        sr_aj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[ANCHO + 4*i +: 4] >= 4'd5) begin
                sr_aj[ANCHO + 4*i +: 4] = sr_q[ANCHO + 4*i +: 4] + 4'd3;
            end
        end
        sr_desp = {sr_aj[SW-2:0], 1'b0};
        bcd_mil = sr_desp[SW-1  -: 4];
        bcd_cen = sr_desp[SW-5  -: 4];
        bcd_dec = sr_desp[SW-9  -: 4];
        bcd_uni = sr_desp[SW-13 -: 4];
    end

    // Next-state and output-register logic.
    // The digit registers load on the final shift edge, which is the edge
    // that enters FIN. This makes the new digits visible during the same
    // cycle that `listo` is high.
    always_comb begin
        estado_d = estado_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        uni_d    = uni_q;
        dec_d    = dec_q;
        cen_d    = cen_q;
        mil_d    = mil_q;
        desb_d   = desb_q;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    sr_d     = {16'b0, binario};
                    cnt_d    = CW'(ANCHO);
                    ovf_d    = (32'(binario) > 32'd9999);
                    estado_d = CONVIERTE;
                end
            end
            CONVIERTE: begin
                sr_d  = sr_desp;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    estado_d = FIN;
                    if (ovf_q) begin
                        // Overflow saturates to 9999. The shift register's own
                        // carry-out beyond 16 BCD bits is meaningless and is ignored.
                        mil_d  = 4'd9;
                        cen_d  = 4'd9;
                        dec_d  = 4'd9;
                        uni_d  = 4'd9;
                        desb_d = 1'b1;
                    end else begin
                        mil_d  = bcd_mil;
                        cen_d  = bcd_cen;
                        dec_d  = bcd_dec;
                        uni_d  = bcd_uni;
                        desb_d = 1'b0;
`ifdef BLANCO_CEROS_EN
                        // Blank from the top down, stopping at the first nonzero digit.
                        if (bcd_mil == 4'd0) begin
                            mil_d = 4'hF;
                            if (bcd_cen == 4'd0) begin
                                cen_d = 4'hF;
                                if (bcd_dec == 4'd0) begin
                                    dec_d = 4'hF;
                                end
                            end
                        end
`endif
                    end
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            sr_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            uni_q    <= 4'h0;
            dec_q    <= RST_DEC;
            cen_q    <= RST_CEN;
            mil_q    <= RST_MIL;
            desb_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            uni_q    <= uni_d;
            dec_q    <= dec_d;
            cen_q    <= cen_d;
            mil_q    <= mil_d;
            desb_q   <= desb_d;
        end
    end

    assign ocupado  = (estado_q != REPOSO);
    assign listo    = (estado_q == FIN);
    assign desborde = desb_q;
    assign unidades = uni_q;
    assign decenas  = dec_q;
    assign centenas = cen_q;
    assign millares = mil_q;

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// -----------------------------------------------------------------------------
// Testbench for convertidor_binario_bcd (ANCHO = 14).
// Expected results come from an arithmetic model (divide/modulo). Each one is
// queued together with its expected `listo` cycle when a start is driven, then
// popped and compared whenever `listo` is observed.
// -----------------------------------------------------------------------------
module tb_convertidor_binario_bcd;

    localparam int ANCHO = 14;

`ifdef BLANCO_CEROS_EN
    localparam logic [16:0] RST_VAL = {1'b0, 4'hF, 4'hF, 4'hF, 4'h0};
`else
    localparam logic [16:0] RST_VAL = 17'h0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inicio = 1'b0;
    logic [ANCHO-1:0] binario = '0;
    logic             ocupado, listo, desborde;
    logic [3:0]       unidades, decenas, centenas, millares;

    convertidor_binario_bcd #(.ANCHO(ANCHO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .binario  (binario),
        .ocupado  (ocupado),
        .listo    (listo),
        .desborde (desborde),
        .unidades (unidades),
        .decenas  (decenas),
        .centenas (centenas),
        .millares (millares)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    int          exp_cyc_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_listo = 0;
    bit          last_listo = 1'b0;

    // Packed result: {desborde, millares, centenas, decenas, unidades}
    function automatic logic [16:0] model(input int v);
        int         x;
        logic       ov;
        logic [3:0] m, c, d, u;
        ov = (v > 9999);
        x  = ov ? 9999 : v;
        m  = 4'(x / 1000);
        c  = 4'((x / 100) % 10);
        d  = 4'((x / 10) % 10);
        u  = 4'(x % 10);
`ifdef BLANCO_CEROS_EN
        if (m == 4'd0) begin
            m = 4'hF;
            if (c == 4'd0) begin
                c = 4'hF;
                if (d == 4'd0) d = 4'hF;
            end
        end
`endif
        return {ov, m, c, d, u};
    endfunction

    function automatic logic [16:0] observed();
        return {desborde, millares, centenas, decenas, unidades};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: sample 1 ns after the rising edge and score any listo pulse.
    task automatic tick();
        logic [16:0] e;
        int          ec;
        @(posedge clk);
        #1;
        cyc++;
        last_listo = listo;
        if (listo) begin
            n_listo++;
            chk("listo_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("digits", 32'(observed()), 32'(e));
                chk("latency", 32'(cyc), 32'(ec));
            end
        end
    endtask

    task automatic start(input int v);
        binario = ANCHO'(v);
        inicio  = 1'b1;
        exp_q.push_back(model(v));
        exp_cyc_q.push_back(cyc + ANCHO + 1);
        tick();
        inicio = 1'b0;
        chk("ocupado_after_accept", 32'(ocupado), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_before_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic conv(input int v);
        start(v);
        wait_done(40);
        tick();
        chk("listo_one_cycle", 32'(listo), 32'd0);
        chk("ocupado_idle", 32'(ocupado), 32'd0);
        chk("hold_after_fin", 32'(observed()), 32'(model(v)));
    endtask

    initial begin
        int nl;
        int low;
        int k;
        int v;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_digits", 32'(observed()), 32'(RST_VAL));
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- basic conversions ----------------
        conv(1234);
        repeat (5) tick();
        chk("hold_idle_1234", 32'(observed()), 32'(model(1234)));
        conv(9999);
        conv(10000);
        conv(16383);
        conv(7);
        conv(0);
        conv(1005);
        conv(9);
        conv(10);
        conv(100);

        // ---------------- inicio ignored while busy ----------------
        nl = n_listo;
        start(1234);
        repeat (4) tick();
        binario = ANCHO'(42);
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        binario = '0;
        wait_done(40);
        repeat (20) tick();
        chk("single_listo_when_ignored", 32'(n_listo - nl), 32'd1);
        chk("ignored_result", 32'(observed()), 32'(model(1234)));

        // ---------------- reset mid-conversion ----------------
        start(4321);
        repeat (7) tick();
        rst_n   = 1'b0;
        inicio  = 1'b1;            // reset wins over a same-edge start
        binario = ANCHO'(999);
        tick();
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk("abort_digits", 32'(observed()), 32'(RST_VAL));
        chk("abort_listo", 32'(listo), 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        inicio = 1'b0;
        rst_n  = 1'b1;
        nl = n_listo;
        repeat (20) tick();
        chk("abort_no_listo", 32'(n_listo - nl), 32'd0);
        chk("abort_still_idle", 32'(ocupado), 32'd0);
        conv(56);

        // ---------------- back-to-back with inicio held ----------------
        binario = ANCHO'(100);
        inicio  = 1'b1;
        exp_q.push_back(model(100));
        exp_cyc_q.push_back(cyc + ANCHO + 1);
        low = 0;
        k   = 0;
        for (int t = 0; t < 120 && k < 4; t++) begin
            tick();
            if (!ocupado) low++;
            if (last_listo) begin
                k++;
                if (k < 4) begin
                    v = (k % 2 == 1) ? 200 : 100;
                    binario = ANCHO'(v);
                    exp_q.push_back(model(v));
                    exp_cyc_q.push_back(cyc + ANCHO + 2);
                end else begin
                    inicio = 1'b0;
                end
            end
        end
        chk("b2b_conversions", 32'(k), 32'd4);
        chk("b2b_idle_cycles", 32'(low), 32'd3);
        repeat (20) tick();
        chk("b2b_final_hold", 32'(observed()), 32'(model(200)));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
